mem_stage: RTL and testbench

//  RISC-V MEM stage, directly downstream of the EX/MEM pipeline register.
//  - Takes ALU result/address, store data, rd and control.
//  - Runs loads/stores over a req/ack data-memory port and stalls the pipeline while a transfer is outstanding.
//  - Applies byte/half/word lane alignment and load sign extension.
//  - Registers the write-back result, so it also acts as the MEM/WB pipeline register.

---
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RISC-V MEM stage and MEM/WB register: drives the req/ack data port, aligns store lanes, extracts loads.
// Latency 1 for ALU ops, >=2 for loads/stores; stall is combinational and held while a transfer is outstanding.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic        memtoreg_in,
    input  logic        we_in,
    input  logic        reg_en_in,
    input  logic [2:0]  funct3_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_en,
    output logic        misalign_err,
    output logic        bus_err
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic        TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_en_q, reg_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_en_q, wb_reg_en_d;
    logic        misalign_err_q, misalign_err_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op, bad_f3, misaligned, access_bad, access_ok, timeout_hit;
    logic [31:0] st_wdata, rd_shift, ld_val;
    logic [3:0]  st_wstrb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        mem_op     = memtoreg_in | we_in;
        bad_f3     = (funct3_in == 3'b011) || (funct3_in[2:1] == 2'b11);
        misaligned = ((funct3_in[1:0] == 2'b01) && alu_result_in[0]) ||
                     ((funct3_in[1:0] == 2'b10) && (alu_result_in[1:0] != 2'b00));
        access_bad = mem_op && (bad_f3 || misaligned);
        access_ok  = mem_op && !access_bad;

        case (funct3_in[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << alu_result_in[1:0];
                st_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                st_wstrb = 4'b0011 << alu_result_in[1:0];
                st_wdata = {2{store_data_in[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = store_data_in;
            end
        endcase

        // Halves are aligned by construction, so a byte-granular shift serves both sizes.
        rd_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
        ld_byte  = rd_shift[7:0];
        ld_half  = rd_shift[15:0];
        case (funct3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'b0, ld_byte};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = dmem_rdata;
        endcase

        timeout_hit = TO_EN && (cnt_q == TO_LAST);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        funct3_d       = funct3_q;
        rd_d           = rd_q;
        reg_en_d       = reg_en_q;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_en_d    = wb_reg_en_q;
        misalign_err_d = 1'b0;
        bus_err_d      = 1'b0;
        stall          = 1'b0;

        if (state_q == IDLE) begin
            if (access_bad) begin
                misalign_err_d = 1'b1;
                wb_reg_en_d    = 1'b0;
            end else if (access_ok) begin
                stall       = 1'b1;
                state_d     = WAIT;
                cnt_d       = '0;
                addr_d      = alu_result_in;
                we_d        = we_in;
                wdata_d     = st_wdata;
                wstrb_d     = st_wstrb;
                funct3_d    = funct3_in;
                rd_d        = rd_in;
                reg_en_d    = reg_en_in;
                wb_reg_en_d = 1'b0;
            end else begin
                wb_data_d   = alu_result_in;
                wb_rd_d     = rd_in;
                wb_reg_en_d = reg_en_in;
            end
        end else begin
            // An ack arriving in the last allowed cycle takes priority over the abort.
            if (dmem_ack) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (we_q) begin
                    wb_reg_en_d = 1'b0;
                end else begin
                    wb_data_d   = ld_val;
                    wb_rd_d     = rd_q;
                    wb_reg_en_d = reg_en_q;
                end
            end else if (timeout_hit) begin
                state_d     = IDLE;
                cnt_d       = '0;
                bus_err_d   = 1'b1;
                wb_reg_en_d = 1'b0;
            end else begin
                stall       = 1'b1;
                cnt_d       = cnt_q + 32'd1;
                wb_reg_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            funct3_q       <= '0;
            rd_q           <= '0;
            reg_en_q       <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_en_q    <= 1'b0;
            misalign_err_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            funct3_q       <= funct3_d;
            rd_q           <= rd_d;
            reg_en_q       <= reg_en_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_en_q    <= wb_reg_en_d;
            misalign_err_q <= misalign_err_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign dmem_req     = (state_q == WAIT);
    assign dmem_we      = we_q;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign dmem_wstrb   = wstrb_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_en    = wb_reg_en_q;
    assign misalign_err = misalign_err_q;
    assign bus_err      = bus_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level expectations per instruction, compared every cycle,
// plus literal expectations for the hand-worked cases.
module tb_mem_stage;
    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] alu_result_in, store_data_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic        memtoreg_in, we_in, reg_en_in, dmem_ack;
    logic [2:0]  funct3_in;
    logic        dmem_req, dmem_we, stall, wb_reg_en, misalign_err, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    always #5 clock = ~clock;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in), .rd_in(rd_in),
        .memtoreg_in(memtoreg_in), .we_in(we_in), .reg_en_in(reg_en_in), .funct3_in(funct3_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_en(wb_reg_en),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt = 0;
    int req_cnt = 0;
    logic chk_on = 1'b0;
    logic [31:0] last_addr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic        last_we = 1'b0;

    // Expected outputs for the current cycle, and registered results due at the next edge.
    logic        e_stall = 0, e_req = 0, e_we = 0, e_wb_en = 0, e_mis = 0, e_bus = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_wb_data = '0;
    logic [3:0]  e_wstrb = '0;
    logic [4:0]  e_wb_rd = '0;
    logic        p_wb_en = 0, p_mis = 0, p_bus = 0;
    logic [31:0] p_wb_data = '0;
    logic [4:0]  p_wb_rd = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic compare_outputs();
        if (stall) stall_cnt++;
        if (dmem_req) begin
            req_cnt++;
            last_addr  = dmem_addr;
            last_wdata = dmem_wdata;
            last_wstrb = dmem_wstrb;
            last_we    = dmem_we;
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("dmem_req", 32'(dmem_req), 32'(e_req));
        if (e_req) begin
            chk("dmem_we", 32'(dmem_we), 32'(e_we));
            chk("dmem_addr", dmem_addr, e_addr);
            if (e_we) begin
                chk("dmem_wdata", dmem_wdata, e_wdata);
                chk("dmem_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
            end
        end
        chk("wb_reg_en", 32'(wb_reg_en), 32'(e_wb_en));
        chk("misalign_err", 32'(misalign_err), 32'(e_mis));
        chk("bus_err", 32'(bus_err), 32'(e_bus));
        if (e_wb_en) begin
            chk("wb_data", wb_data, e_wb_data);
            chk("wb_rd", 32'(wb_rd), 32'(e_wb_rd));
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (chk_on) compare_outputs();
        @(posedge clock);
        e_wb_en   = p_wb_en;
        e_wb_data = p_wb_data;
        e_wb_rd   = p_wb_rd;
        e_mis     = p_mis;
        e_bus     = p_bus;
        p_mis     = 1'b0;
        p_bus     = 1'b0;
        #1;
    endtask

    // delay = WAIT cycles without ack before the ack; delay >= TO means the memory never answers.
    task automatic do_instr(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                            input logic mtr, input logic we, input logic ren, input logic [2:0] f3,
                            input int delay, input logic [31:0] rdata);
        int nb, k, last;
        logic legal, bad, timeout;
        logic [31:0] mask, lv;
        alu_result_in = alu; store_data_in = sd; rd_in = rd;
        memtoreg_in = mtr; we_in = we; reg_en_in = ren; funct3_in = f3;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        nb    = 1 << f3[1:0];
        k     = int'(alu[1:0]);
        legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        bad   = (mtr || we) && (!legal || (k % nb) != 0);
        if (!(mtr || we) || bad) begin
            e_stall = 1'b0; e_req = 1'b0;
            p_wb_en = bad ? 1'b0 : ren; p_wb_data = alu; p_wb_rd = rd; p_mis = bad;
            tick();
        end else begin
            e_stall = 1'b1; e_req = 1'b0; p_wb_en = 1'b0;
            tick();
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            lv   = (rdata >> (8 * k)) & mask;
            if (!f3[2] && nb < 4 && lv[8 * nb - 1]) lv = lv | ~mask;
            for (int i = 0; i < 4; i++) begin
                e_wdata[8 * i +: 8] = sd[8 * (i % nb) +: 8];
                e_wstrb[i]          = (i >= k) && (i < k + nb);
            end
            e_addr = {alu[31:2], 2'b00};
            e_we   = we;
            e_req  = 1'b1;
            timeout = (delay >= TO);
            last    = timeout ? TO - 1 : delay;
            for (int w = 0; w <= last; w++) begin
                dmem_ack   = !timeout && (w == last);
                dmem_rdata = dmem_ack ? rdata : $urandom;
                e_stall    = (w != last);
                p_wb_en    = (dmem_ack && !we) ? ren : 1'b0;
                p_wb_data  = lv;
                p_wb_rd    = rd;
                p_bus      = timeout && (w == last);
                tick();
            end
            dmem_ack = 1'b0;
        end
    endtask

    task automatic bubble();
        do_instr(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 0, 32'h0);
    endtask

    initial begin
        int s0, r0, r, dly;
        logic [31:0] alu, sd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  op;
        logic        ren;

        reset = 1'b1;
        alu_result_in = '0; store_data_in = '0; rd_in = '0;
        memtoreg_in = 0; we_in = 0; reg_en_in = 0; funct3_in = '0;
        dmem_rdata = '0; dmem_ack = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_reg_en", 32'(wb_reg_en), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
        reset  = 1'b0;
        chk_on = 1'b1;

        // ALU op writes back after one cycle without stalling.
        s0 = stall_cnt;
        do_instr(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 3'b000, 0, 32'h0);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", 32'(wb_rd), 32'd5);
        chk("alu_wb_reg_en", 32'(wb_reg_en), 32'd1);
        chk("alu_no_stall", 32'(stall_cnt - s0), 32'd0);

        // LB at 0x103, ack in the last WAIT cycle before the timeout would fire.
        s0 = stall_cnt;
        do_instr(32'h103, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b000, 3, 32'h80FF_FFFF);
        chk("lb_stall_cycles", 32'(stall_cnt - s0), 32'd4);
        chk("lb_addr", last_addr, 32'h100);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_reg_en", 32'(wb_reg_en), 32'd1);
        bubble();
        chk("lb_wb_one_cycle", 32'(wb_reg_en), 32'd0);

        // SH at 0x106 with immediate ack.
        s0 = stall_cnt; r0 = req_cnt;
        do_instr(32'h106, 32'hAAAA_BEEF, 5'd4, 1'b0, 1'b1, 1'b1, 3'b001, 0, 32'h0);
        chk("sh_wstrb", 32'(last_wstrb), 32'h0000_000C);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        chk("sh_we", 32'(last_we), 32'd1);
        chk("sh_stall_cycles", 32'(stall_cnt - s0), 32'd1);
        chk("sh_req_cycles", 32'(req_cnt - r0), 32'd1);
        chk("sh_no_wb", 32'(wb_reg_en), 32'd0);

        // Misaligned LW.
        s0 = stall_cnt; r0 = req_cnt;
        do_instr(32'h102, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 3'b010, 0, 32'h0);
        chk("lw_mis_err", 32'(misalign_err), 32'd1);
        chk("lw_mis_wb", 32'(wb_reg_en), 32'd0);
        chk("lw_mis_nostall", 32'(stall_cnt - s0), 32'd0);
        chk("lw_mis_noreq", 32'(req_cnt - r0), 32'd0);
        bubble();
        chk("mis_pulse_end", 32'(misalign_err), 32'd0);

        // LW at 0x200 that never gets an ack.
        r0 = req_cnt;
        do_instr(32'h200, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 3'b010, 9, 32'h0);
        chk("to_req_cycles", 32'(req_cnt - r0), 32'd4);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_no_wb", 32'(wb_reg_en), 32'd0);
        do_instr(32'h55, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 3'b000, 0, 32'h0);
        chk("after_to_wb", wb_data, 32'h55);
        chk("after_to_bus_clr", 32'(bus_err), 32'd0);

        // Reset in the second WAIT cycle of an LHU, followed by a late ack.
        alu_result_in = 32'h302; rd_in = 5'd9; memtoreg_in = 1'b1; we_in = 1'b0;
        reg_en_in = 1'b1; funct3_in = 3'b101; dmem_ack = 1'b0;
        e_stall = 1'b1; e_req = 1'b0; p_wb_en = 1'b0;
        tick();
        e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300;
        tick();
        reset = 1'b1;
        p_wb_data = '0; p_wb_rd = '0;
        tick();
        reset = 1'b0;
        memtoreg_in = 1'b0; reg_en_in = 1'b0; alu_result_in = '0; rd_in = '0; funct3_in = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        e_stall = 1'b0; e_req = 1'b0;
        chk("wrst_req", 32'(dmem_req), 32'd0);
        chk("wrst_wb_reg_en", 32'(wb_reg_en), 32'd0);
        chk("wrst_wb_data", wb_data, 32'd0);
        chk("wrst_wb_rd", 32'(wb_rd), 32'd0);
        chk("wrst_addr", dmem_addr, 32'd0);
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_wb", 32'(wb_reg_en), 32'd0);
        chk("late_ack_req", 32'(dmem_req), 32'd0);

        // Randomized instruction stream.
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(0, 9);
            alu = $urandom;
            sd  = $urandom;
            rd  = 5'($urandom);
            ren = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, TO + 1);
            op  = (r < 3) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            if (r == 9) begin
                f3 = 3'($urandom);
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            do_instr(alu, sd, rd, op[1], op[0], ren, f3, dly, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
